// File: rtl/idex_hazard_stage_pkg.sv
// Shared CPU pipeline definitions: datapath widths and the ID/EX control record
// that the EX/MEM stage also reuses.
package idex_hazard_stage_pkg;
   localparam int DATA_W = 16;
   localparam int REG_AW = 4;
   localparam int OP_W   = 4;

   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic [OP_W-1:0] aluop;
   } idex_ctrl_t;
endpackage

// File: rtl/idex_hazard_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in decode. Register 0 is an ordinary register here.
module hazard_detect #(
   parameter int REG_AW = 4
) (
   input  logic              i_id_valid,
   input  logic [REG_AW-1:0] i_id_r1,
   input  logic [REG_AW-1:0] i_id_r2,
   input  logic              i_id_use_r1,
   input  logic              i_id_use_r2,
   input  logic              i_ex_valid,
   input  logic              i_ex_memread,
   input  logic [REG_AW-1:0] i_ex_rd,
   output logic              o_load_use
);
   logic w_hit_r1, w_hit_r2;

   assign w_hit_r1   = i_id_use_r1 && (i_id_r1 == i_ex_rd);
   assign w_hit_r2   = i_id_use_r2 && (i_id_r2 == i_ex_rd);
   assign o_load_use = i_id_valid && i_ex_valid && i_ex_memread && (w_hit_r1 || w_hit_r2);
endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, flush and EX-hold handling,
// plus a saturating count of inserted load-use bubbles.
module idex_hazard_stage #(
   parameter int DATA_W = idex_hazard_stage_pkg::DATA_W,
   parameter int REG_AW = idex_hazard_stage_pkg::REG_AW,
   parameter int OP_W   = idex_hazard_stage_pkg::OP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_r1,
   input  logic [REG_AW-1:0] id_r2,
   input  logic              id_use_r1,
   input  logic              id_use_r2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_op1,
   input  logic [DATA_W-1:0] id_op2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [OP_W-1:0]   id_aluop,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              ex_hold,
   input  logic              flush,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_r1,
   output logic [REG_AW-1:0] ex_r2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [OP_W-1:0]   ex_aluop,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              stall,
   output logic [7:0]        bubble_cnt
);
   import idex_hazard_stage_pkg::*;

   localparam int CTRL_OP_W = idex_hazard_stage_pkg::OP_W;

   idex_ctrl_t        r_ctrl;
   logic [REG_AW-1:0] r_r1, r_r2, r_rd;
   logic [DATA_W-1:0] r_op1, r_op2, r_imm;
   logic [7:0]        r_bubble_cnt;
   logic              w_load_use;
   logic              w_bubble;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
      .i_id_valid   (id_valid),
      .i_id_r1      (id_r1),
      .i_id_r2      (id_r2),
      .i_id_use_r1  (id_use_r1),
      .i_id_use_r2  (id_use_r2),
      .i_ex_valid   (r_ctrl.valid),
      .i_ex_memread (r_ctrl.memread),
      .i_ex_rd      (r_rd),
      .o_load_use   (w_load_use)
   );

   // A flush kills the decode slot, so a hazard against it needs no stall.
   assign stall    = ex_hold | (w_load_use & ~flush);
   assign w_bubble = flush | w_load_use;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl <= '0;
         r_r1   <= '0;
         r_r2   <= '0;
         r_rd   <= '0;
         r_op1  <= '0;
         r_op2  <= '0;
         r_imm  <= '0;
      end else if (!ex_hold) begin
         if (w_bubble) begin
            r_ctrl.valid    <= 1'b0;
            r_ctrl.regwrite <= 1'b0;
            r_ctrl.memread  <= 1'b0;
            r_ctrl.memwrite <= 1'b0;
         end else begin
            r_ctrl.valid    <= id_valid;
            r_ctrl.regwrite <= id_valid & id_regwrite;
            r_ctrl.memread  <= id_valid & id_memread;
            r_ctrl.memwrite <= id_valid & id_memwrite;
            r_ctrl.aluop    <= CTRL_OP_W'(id_aluop);
            r_r1            <= id_r1;
            r_r2            <= id_r2;
            r_rd            <= id_rd;
            r_op1           <= id_op1;
            r_op2           <= id_op2;
            r_imm           <= id_imm;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_bubble_cnt <= '0;
      else if (!ex_hold && !flush && w_load_use && (r_bubble_cnt != 8'hFF))
         r_bubble_cnt <= r_bubble_cnt + 8'd1;
   end

   assign ex_valid    = r_ctrl.valid;
   assign ex_regwrite = r_ctrl.regwrite;
   assign ex_memread  = r_ctrl.memread;
   assign ex_memwrite = r_ctrl.memwrite;
   assign ex_aluop    = OP_W'(r_ctrl.aluop);
   assign ex_r1       = r_r1;
   assign ex_r2       = r_r2;
   assign ex_rd       = r_rd;
   assign ex_op1      = r_op1;
   assign ex_op2      = r_op2;
   assign ex_imm      = r_imm;
   assign bubble_cnt  = r_bubble_cnt;
endmodule

// File: tb/tb_idex_hazard_stage.sv
// Randomized + directed scoreboard bench for idex_hazard_stage against a
// cycle-level behavioural model of the ID/EX stage rules.
module tb_idex_hazard_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid, id_use_r1, id_use_r2;
   logic [3:0]  id_r1, id_r2, id_rd, id_aluop;
   logic [15:0] id_op1, id_op2, id_imm;
   logic        id_regwrite, id_memread, id_memwrite, ex_hold, flush;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall;
   logic [3:0]  ex_r1, ex_r2, ex_rd, ex_aluop;
   logic [15:0] ex_op1, ex_op2, ex_imm;
   logic [7:0]  bubble_cnt;

   typedef struct packed {
      logic        valid;
      logic [3:0]  r1, r2;
      logic        u1, u2;
      logic [3:0]  rd;
      logic [15:0] op1, op2, imm;
      logic [3:0]  aluop;
      logic        rw, mr, mw, hold, flush;
   } stim_t;

   typedef struct packed {
      logic        valid, rw, mr, mw;
      logic [3:0]  r1, r2, rd, aluop;
      logic [15:0] op1, op2, imm;
      logic        dk;     // data fields defined (last action was a load)
      logic [7:0]  cnt;
   } exp_t;

   exp_t m;
   exp_t q_state[$];
   logic q_stall[$];
   int   total = 0;
   int   bad = 0;

   idex_hazard_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
      .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .id_rd(id_rd), .id_op1(id_op1),
      .id_op2(id_op2), .id_imm(id_imm), .id_aluop(id_aluop), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .ex_hold(ex_hold), .flush(flush),
      .ex_valid(ex_valid), .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_rd(ex_rd), .ex_op1(ex_op1),
      .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_aluop(ex_aluop), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .stall(stall), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t lw(input logic [3:0] rd);
      stim_t s;
      s = '0; s.valid = 1'b1; s.rd = rd; s.mr = 1'b1; s.rw = 1'b1; s.aluop = 4'h2;
      s.imm = 16'h0040;
      return s;
   endfunction

   function automatic stim_t add(input logic [3:0] r1, input logic u1,
                                 input logic [3:0] r2, input logic u2, input logic [3:0] rd);
      stim_t s;
      s = '0; s.valid = 1'b1; s.r1 = r1; s.u1 = u1; s.r2 = r2; s.u2 = u2; s.rd = rd;
      s.rw = 1'b1; s.aluop = 4'h1; s.op1 = 16'h1234; s.op2 = 16'h00FF;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      id_valid = s.valid; id_r1 = s.r1; id_r2 = s.r2; id_use_r1 = s.u1; id_use_r2 = s.u2;
      id_rd = s.rd; id_op1 = s.op1; id_op2 = s.op2; id_imm = s.imm; id_aluop = s.aluop;
      id_regwrite = s.rw; id_memread = s.mr; id_memwrite = s.mw;
      ex_hold = s.hold; flush = s.flush;
   endtask

   // One cycle: drive at negedge, push expected stall and expected post-edge state.
   task automatic drive(input stim_t s);
      bit lu;
      @(negedge clk);
      apply(s);
      lu = s.valid && m.valid && m.mr &&
           ((s.u1 && s.r1 == m.rd) || (s.u2 && s.r2 == m.rd));
      q_stall.push_back(s.hold || (lu && !s.flush));
      if (!s.hold) begin
         if (s.flush || lu) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.dk = 0;
            if (!s.flush && m.cnt < 8'd255) m.cnt = m.cnt + 8'd1;
         end else begin
            m.valid = s.valid; m.rw = s.valid & s.rw; m.mr = s.valid & s.mr;
            m.mw = s.valid & s.mw; m.r1 = s.r1; m.r2 = s.r2; m.rd = s.rd;
            m.op1 = s.op1; m.op2 = s.op2; m.imm = s.imm; m.aluop = s.aluop; m.dk = 1;
         end
      end
      q_state.push_back(m);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: state after each edge, then stall once the next inputs settle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (q_state.size() != 0) begin
            e = q_state.pop_front();
            check("ctrl", 64'({ex_valid, ex_regwrite, ex_memread, ex_memwrite}),
                  64'({e.valid, e.rw, e.mr, e.mw}));
            check("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt));
            if (e.dk) begin
               check("regs", 64'({ex_r1, ex_r2, ex_rd, ex_aluop}), 64'({e.r1, e.r2, e.rd, e.aluop}));
               check("data", 64'({ex_op1, ex_op2, ex_imm}), 64'({e.op1, e.op2, e.imm}));
            end
         end
         @(negedge clk); #2;
         if (q_stall.size() != 0) check("stall", 64'(stall), 64'(q_stall.pop_front()));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      apply(idle());
      m = '0;
      #12;
      check("reset_outputs", 64'({ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall, bubble_cnt}), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // load-use with r1
      drive(lw(4'h1));
      drive(add(4'h1, 1, 4'h3, 1, 4'h2));
      drive(add(4'h1, 1, 4'h3, 1, 4'h2));
      drive(idle());
      // no hazard: producer is not a load
      drive(add(4'h0, 0, 4'h0, 0, 4'h1));
      drive(add(4'h1, 1, 4'h2, 0, 4'h4));
      // unused source matches the load destination
      drive(lw(4'h6));
      drive(add(4'h0, 1, 4'h6, 0, 4'h7));
      // hold dominates a hazard for three cycles, then one bubble
      drive(lw(4'h3));
      s = add(4'h3, 1, 4'h0, 0, 4'h8); s.hold = 1'b1;
      repeat (3) drive(s);
      s.hold = 1'b0;
      drive(s);
      drive(s);
      // flush beats load-use
      drive(lw(4'h5));
      s = add(4'h5, 1, 4'h0, 0, 4'h9); s.flush = 1'b1;
      drive(s);
      drive(idle());
      // 300 back-to-back load-use events saturate the counter
      drive(lw(4'h0));
      s = lw(4'h0); s.u1 = 1'b1;
      repeat (600) drive(s);
      // async reset in the middle of a load-use stall
      drive(lw(4'h2));
      @(negedge clk);
      apply(add(4'h2, 1, 4'h0, 0, 4'hA));
      #3 rst_n = 1'b0;
      #1;
      check("async_reset", 64'({ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall, bubble_cnt,
                                ex_r1, ex_rd, ex_op1}), 64'd0);
      m = '0;
      ex_hold = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      // randomized traffic biased toward hazards
      repeat (400) begin
         s = '0;
         s.valid = ($urandom_range(0, 99) < 85);
         s.r1 = 4'($urandom_range(0, 3)); s.r2 = 4'($urandom_range(0, 3));
         s.u1 = 1'($urandom); s.u2 = 1'($urandom);
         s.rd = 4'($urandom_range(0, 3));
         s.op1 = 16'($urandom); s.op2 = 16'($urandom); s.imm = 16'($urandom);
         s.aluop = 4'($urandom);
         s.rw = 1'($urandom); s.mr = ($urandom_range(0, 99) < 45); s.mw = 1'($urandom);
         s.hold = ($urandom_range(0, 99) < 15); s.flush = ($urandom_range(0, 99) < 10);
         drive(s);
      end
      drive(idle());
      repeat (3) @(posedge clk);
      #2;
      check("queues_drained", 64'(q_state.size() + q_stall.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/idex_hazard_stage.md
IDEX_HAZARD_STAGE -- requirements
Module: idex_hazard_stage

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, operand/immediate width; REG_AW, default 4, register-address width (16 registers); OP_W, default 4, ALU-op width.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 single clock, rising edge; rst_n in 1 reset, asynchronous, active-low.
REQ-003 SHALL have ID-side inputs: id_valid in 1 decode slot holds an instruction; id_r1, id_r2 in REG_AW source registers; id_use_r1, id_use_r2 in 1 source actually read; id_rd in REG_AW destination; id_op1, id_op2, id_imm in DATA_W; id_aluop in OP_W; id_regwrite, id_memread, id_memwrite in 1.
REQ-004 SHALL have control inputs: ex_hold in 1 EX busy (multi-cycle op) and must freeze; flush in 1 branch resolved taken, kill the decode-slot instruction.
REQ-005 SHALL have EX-side outputs: ex_valid 1; ex_r1, ex_r2 REG_AW, which drive the forwarding unit's r1IDEX/r2IDEX; ex_rd REG_AW; ex_op1, ex_op2, ex_imm DATA_W; ex_aluop OP_W; ex_regwrite, ex_memread, ex_memwrite 1.
REQ-006 SHALL have status outputs: stall out 1 freezes PC and IF/ID; bubble_cnt out 8 count of load-use bubbles inserted.

Function
REQ-007 load_use SHALL be combinational: id_valid & ex_valid & ex_memread & ((id_use_r1 & id_r1==ex_rd) | (id_use_r2 & id_r2==ex_rd)); no register is hardwired, so address 0 compares like any other.
REQ-008 stall SHALL equal ex_hold | (load_use & ~flush), with zero cycles of latency.
REQ-009 On each clock edge the ID/EX register SHALL take exactly one action, in priority order: ex_hold -> all outputs keep their values; else flush -> bubble; else load_use -> bubble; else load the id_* inputs and set ex_valid=id_valid.
REQ-010 A bubble SHALL clear ex_valid, ex_regwrite, ex_memread and ex_memwrite; the data, address and aluop fields may keep their old values but are don't-care.
REQ-011 When id_valid=0 the register SHALL still load the id_* inputs, with all control bits forced to 0.
REQ-012 A load-use stall SHALL last exactly one cycle per load; after the bubble the load is in MEM and the forwarding unit resolves the dependency.
REQ-013 bubble_cnt SHALL increment only on an edge where a load-use bubble is inserted (no ex_hold, no flush, load_use=1), and SHALL saturate at 255 without wrapping.
REQ-014 When ex_hold and load_use are both asserted, no bubble SHALL be inserted and bubble_cnt SHALL not change; stall stays 1.
REQ-015 When flush and load_use are both asserted, flush SHALL take precedence: one bubble is inserted, stall=ex_hold, and bubble_cnt does not change.

Reset
REQ-016 rst_n low SHALL immediately clear every registered output and bubble_cnt to 0, with ex_valid=0.
REQ-017 Reset asserted mid-stall SHALL discard the stall; after release, stall reflects only the current inputs.
REQ-018 Reset release SHALL take effect on the first rising clk edge where rst_n=1.

Structure
REQ-019 A shared CPU package SHALL hold DATA_W, REG_AW, OP_W and an idex_ctrl_t record {valid, regwrite, memread, memwrite, aluop}, to be reused by the EX/MEM stage.
REQ-020 The load-use comparison SHALL live in one combinational sub-module, hazard_detect; the register, priority logic and counter SHALL stay in idex_hazard_stage.

Verification
REQ-021 Load-use: EX holds lw with ex_rd=0001 and ex_memread=1; ID holds add with r1=0001 and use_r1=1 -> stall=1 that cycle; next cycle ex_valid=0 and bubble_cnt=1; the cycle after, add is in EX with ex_r1=0001 and stall=0.
REQ-022 No hazard: EX holds add with rd=0001 (memread=0); ID reads r1=0001 -> stall=0, and the instruction loads next edge with ex_r1=0001.
REQ-023 Unused source: lw with rd=0110 in EX; ID has id_r2=0110 but use_r2=0 -> stall=0 and no bubble.
REQ-024 Hold vs hazard: ex_hold=1 for 3 cycles with load_use=1 -> EX outputs are unchanged, stall=1 throughout, bubble_cnt unchanged; on the first cycle after ex_hold drops, one bubble is inserted.
REQ-025 Flush: flush=1 with load_use=1 -> stall=0, a bubble is inserted next edge, bubble_cnt unchanged; separately, 300 back-to-back load-use events -> bubble_cnt=255.
REQ-026 Async reset: drive rst_n low between clock edges during a stall -> all outputs are 0 before the next edge.
